mem_access_unit: RTL and testbench

Load/store sequencer that drives the data-side port of the word-addressed unified memory (Op2En/Op2RW/ReadWriteAddr/DataWrite, read data returned combinationally on Data). It accepts byte-addressed load/store requests from the processor datapath over a valid/ready handshake and checks alignment and range. Sub-word stores are performed as a read-modify-write because the memory is word-only. Results return on a second valid/ready channel.

---
 rtl/mem_access_unit_if.sv | 24 ++
 rtl/mem_access_unit.sv | 97 +++++++++
 tb/tb_mem_access_unit.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: request/response handshake between the datapath and the load/store unit
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte-addressed load/store sequencer for a word-only memory port,
// doing read-modify-write for sub-word stores.
module mem_access_unit #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_access_unit_if.slave   bus,
    output logic               Op2En,
    output logic               Op2RW,
    output logic [31:0]        ReadWriteAddr,
    output logic [31:0]        DataWrite,
    input  logic [31:0]        Data
);
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t      r_state, w_next;
    logic        r_we, r_signed, r_err;
    logic [1:0]  r_size;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic        w_accept, w_err, w_en, w_rw;
    logic [4:0]  w_shamt;
    logic [15:0] w_half;
    logic [31:0] w_mask, w_merged, w_load, w_src_addr, w_dwrite;

    assign bus.req_ready  = r_state == IDLE;
    assign bus.resp_valid = r_state == RESP;
    assign bus.resp_rdata = r_rdata;
    assign bus.resp_err   = r_err;

    assign w_accept = bus.req_valid && bus.req_ready;
    assign w_err    = (bus.req_size == 2'b11)
                   || (bus.req_size == 2'b01 && bus.req_addr[0])
                   || (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00)
                   || ({2'b00, bus.req_addr[31:2]} >= 32'(DEPTH_WORDS));

    // Lane extraction and merge both work on the word read during RD
    assign w_shamt  = {r_addr[1:0], 3'b000};
    assign w_half   = 16'(Data >> w_shamt);
    assign w_load   = r_size == 2'b00 ? {{24{r_signed & w_half[7]}}, w_half[7:0]}
                    : r_size == 2'b01 ? {{16{r_signed & w_half[15]}}, w_half}
                    : Data;
    assign w_mask   = (r_size == 2'b00 ? 32'h0000_00FF : 32'h0000_FFFF) << w_shamt;
    assign w_merged = (Data & ~w_mask) | ((r_wdata << w_shamt) & w_mask);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = w_err ? RESP : (bus.req_we && bus.req_size == 2'b10) ? WR : RD;
            RD:      w_next = r_we ? WR : RESP;
            WR:      w_next = RESP;
            default: if (bus.resp_ready) w_next = IDLE;
        endcase
    end

    // Memory-port outputs are registered from the next state so a write lasts exactly one cycle
    assign w_en       = w_next == RD || w_next == WR;
    assign w_rw       = w_next == WR;
    assign w_src_addr = r_state == IDLE ? bus.req_addr : r_addr;
    assign w_dwrite   = w_rw ? (r_state == IDLE ? bus.req_wdata : w_merged) : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Op2En         <= 1'b0;
            Op2RW         <= 1'b0;
            ReadWriteAddr <= 32'h0;
            DataWrite     <= 32'h0;
            r_we          <= 1'b0;
            r_signed      <= 1'b0;
            r_size        <= 2'b00;
            r_addr        <= 32'h0;
            r_wdata       <= 32'h0;
            r_rdata       <= 32'h0;
            r_err         <= 1'b0;
        end else begin
            Op2En         <= w_en;
            Op2RW         <= w_rw;
            ReadWriteAddr <= w_en ? {2'b00, w_src_addr[31:2]} : 32'h0;
            DataWrite     <= w_dwrite;
            if (w_accept) begin
                r_we     <= bus.req_we;
                r_signed <= bus.req_signed;
                r_size   <= bus.req_size;
                r_addr   <= bus.req_addr;
                r_wdata  <= bus.req_wdata;
                r_rdata  <= 32'h0;
                r_err    <= w_err;
            end
            if (r_state == RD && !r_we) r_rdata <= w_load;
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench for mem_access_unit with a behavioural word memory
// and an independent byte-lane reference model.
module tb_mem_access_unit;
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          en;
        int          wr;
        logic [31:0] waddr;
        logic [31:0] wword;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Op2En, Op2RW;
    logic [31:0] ReadWriteAddr, DataWrite, mem_data;
    logic [31:0] mem     [1024] = '{default: '0};
    logic [31:0] ref_mem [1024] = '{default: '0};
    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    mem_access_unit_if bus();

    mem_access_unit #(.DEPTH_WORDS(1024)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .Op2En(Op2En), .Op2RW(Op2RW), .ReadWriteAddr(ReadWriteAddr),
        .DataWrite(DataWrite), .Data(mem_data)
    );

    always #5 clk = ~clk;

    assign mem_data = (Op2En && ReadWriteAddr < 32'd1024) ? mem[ReadWriteAddr[9:0]] : 32'h0;

    always @(posedge clk) if (Op2En && Op2RW) mem[ReadWriteAddr[9:0]] <= DataWrite;

    function automatic exp_t model(input logic we, input logic [1:0] sz, input logic sg,
                                   input logic [31:0] a, input logic [31:0] wd);
        exp_t       e;
        logic [7:0] b [4];
        logic [31:0] w;
        int         l;
        e = '{rdata: 32'h0, err: 1'b0, lat: 1, en: 0, wr: 0, waddr: 32'h0, wword: 32'h0};
        e.err = sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) || a >= 32'h1000;
        if (e.err) return e;
        w = ref_mem[a[11:2]];
        for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
        l = int'(a[1:0]);
        if (!we) begin
            e.lat = 2; e.en = 1;
            case (sz)
                2'd0:    e.rdata = {{24{sg & b[l][7]}}, b[l]};
                2'd1:    e.rdata = {{16{sg & b[l+1][7]}}, b[l+1], b[l]};
                default: e.rdata = w;
            endcase
        end else begin
            e.wr = 1;
            e.waddr = {2'b00, a[31:2]};
            if (sz == 2'd2) begin
                e.lat = 2; e.en = 1; e.wword = wd;
            end else begin
                e.lat = 3; e.en = 2;
                b[l] = wd[7:0];
                if (sz == 2'd1) b[l+1] = wd[15:8];
                e.wword = {b[3], b[2], b[1], b[0]};
            end
            ref_mem[a[11:2]] = e.wword;
        end
        return e;
    endfunction

    task automatic run_req(input logic we, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd, input int hold);
        exp_t        e;
        int          c, en, wr;
        logic [31:0] snap;
        bit          seen;
        sb.push_back(model(we, sz, sg, a, wd));
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz; bus.req_signed = sg;
        bus.req_addr = a; bus.req_wdata = wd; bus.resp_ready = (hold == 0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0; bus.req_addr = $urandom; bus.req_wdata = $urandom;
        bus.req_size = 2'($urandom); bus.req_we = 1'($urandom); bus.req_signed = 1'($urandom);
        c = 0; en = 0; wr = 0; seen = 1'b0;
        while (!seen && c < 20) begin
            @(negedge clk); c++;
            if (Op2En) en++;
            if (Op2En && Op2RW) begin
                wr++;
                n_tests++;
                if ({ReadWriteAddr, DataWrite} !== {sb[0].waddr, sb[0].wword}) begin
                    n_fail++;
                    $display("FAIL wr_port addr=%0h: got %h/%h want %h/%h", a, ReadWriteAddr, DataWrite, sb[0].waddr, sb[0].wword);
                end
            end
            if (bus.resp_valid) seen = 1'b1;
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL resp_timeout addr=%0h: no resp_valid within 20 cycles", a);
            void'(sb.pop_front());
            return;
        end
        e = sb.pop_front();
        if ({bus.resp_err, bus.resp_rdata} !== {e.err, e.rdata}) begin
            n_fail++;
            $display("FAIL resp addr=%0h: got err=%b rdata=%h want err=%b rdata=%h", a, bus.resp_err, bus.resp_rdata, e.err, e.rdata);
        end
        n_tests++;
        if (c !== e.lat || en !== e.en || wr !== e.wr) begin
            n_fail++;
            $display("FAIL timing addr=%0h: got lat=%0d en=%0d wr=%0d want lat=%0d en=%0d wr=%0d", a, c, en, wr, e.lat, e.en, e.wr);
        end
        n_tests++;
        if (bus.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_in_resp: got %b want 0", bus.req_ready);
        end
        snap = bus.resp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            n_tests++;
            if ({bus.resp_valid, bus.req_ready, bus.resp_rdata} !== {2'b10, snap}) begin
                n_fail++;
                $display("FAIL hold cyc %0d: got v=%b rdy=%b rdata=%h want 1/0/%h", i, bus.resp_valid, bus.req_ready, bus.resp_rdata, snap);
            end
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({bus.req_ready, bus.resp_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL release: got rdy=%b v=%b want 1/0", bus.req_ready, bus.resp_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({Op2En, Op2RW, ReadWriteAddr, DataWrite} !== 66'h0) begin
            n_fail++;
            $display("FAIL reset_mem: got en=%b rw=%b a=%h d=%h want all 0", Op2En, Op2RW, ReadWriteAddr, DataWrite);
        end
        n_tests++;
        if ({bus.req_ready, bus.resp_valid, bus.resp_err, bus.resp_rdata} !== {3'b100, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_resp: got rdy=%b v=%b err=%b rdata=%h want 1/0/0/0", bus.req_ready, bus.resp_valid, bus.resp_err, bus.resp_rdata);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++;
            if ({Op2En, bus.req_ready, bus.resp_valid} !== 3'b010) begin
                n_fail++;
                $display("FAIL idle cyc %0d: got en=%b rdy=%b v=%b want 0/1/0", i, Op2En, bus.req_ready, bus.resp_valid);
            end
        end
    endtask

    task automatic test_word();
        run_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0);
        run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0);
    endtask

    task automatic test_rmw();
        run_req(1'b1, 2'd0, 1'b0, 32'h12, 32'hAAAA_AA55, 0);
        n_tests++;
        if (mem[4] !== 32'hDE55BEEF) begin
            n_fail++;
            $display("FAIL rmw_byte: got %h want de55beef", mem[4]);
        end
        run_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0);
        run_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 0);
        run_req(1'b1, 2'd1, 1'b0, 32'h10, 32'h5555_8001, 0);
        run_req(1'b0, 2'd1, 1'b1, 32'h10, 32'h0, 0);
        run_req(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 0);
        run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0);
    endtask

    task automatic test_errors();
        run_req(1'b0, 2'd1, 1'b0, 32'h11, 32'h0, 0);
        run_req(1'b1, 2'd2, 1'b0, 32'h02, 32'h1234_5678, 0);
        run_req(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 0);
        run_req(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 0);
        run_req(1'b1, 2'd2, 1'b0, 32'hFFC, 32'hCAFE_F00D, 0);
        run_req(1'b0, 2'd2, 1'b0, 32'hFFC, 32'h0, 0);
    endtask

    task automatic test_backpressure();
        run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5);
        run_req(1'b1, 2'd0, 1'b0, 32'h21, 32'h0000_00A5, 3);
    endtask

    task automatic test_back_to_back();
        logic [1:0]  sz;
        logic [31:0] a;
        for (int i = 0; i < 24; i++) begin
            sz = 2'($urandom_range(0, 2));
            a  = 32'($urandom_range(0, 63));
            a  = sz == 2'd1 ? (a & 32'hFFFF_FFFE) : sz == 2'd2 ? (a & 32'hFFFF_FFFC) : a;
            run_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, 0);
        end
    endtask

    task automatic test_reset_mid();
        bit hit = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd1; bus.req_signed = 1'b0;
        bus.req_addr = 32'h22; bus.req_wdata = 32'h0000_7777;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        for (int i = 0; i < 10 && !hit; i++) begin
            @(negedge clk);
            if (Op2En && Op2RW) hit = 1'b1;
        end
        n_tests++;
        if (!hit) begin
            n_fail++;
            $display("FAIL rst_mid_wr: WR cycle not reached within 10 cycles");
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({Op2En, Op2RW, bus.req_ready, bus.resp_valid} !== 4'b0010) begin
            n_fail++;
            $display("FAIL rst_mid_async: got en=%b rw=%b rdy=%b v=%b want 0/0/1/0", Op2En, Op2RW, bus.req_ready, bus.resp_valid);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_tests++;
            if ({Op2En, bus.req_ready, bus.resp_valid} !== 3'b010) begin
                n_fail++;
                $display("FAIL rst_mid_idle cyc %0d: got en=%b rdy=%b v=%b want 0/1/0", i, Op2En, bus.req_ready, bus.resp_valid);
            end
        end
        n_tests++;
        if (mem[8] !== ref_mem[8]) begin
            n_fail++;
            $display("FAIL rst_mid_abandon: got mem[8]=%h want %h", mem[8], ref_mem[8]);
        end
        run_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0; bus.req_signed = 1'b0;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.resp_ready = 1'b1;
        test_reset();
        test_word();
        test_rmw();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
